// File: rtl/sync_fifo_ecc_ctrl.sv
// Synchronous FIFO controller for an external dual-port RAM with SECDED protection.
// Optional `FIFO_ECC_INJECT_EN adds inj_sbe/inj_dbe inputs that corrupt the written codeword.
module sync_fifo_ecc_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  localparam int P = (DATA_WIDTH <= 4)  ? 3 :
                     (DATA_WIDTH <= 11) ? 4 :
                     (DATA_WIDTH <= 26) ? 5 :
                     (DATA_WIDTH <= 57) ? 6 : 7,
  localparam int CW = DATA_WIDTH + P + 1
) (
  input  logic                  clk,
  input  logic                  hw_rst,
`ifdef FIFO_ECC_INJECT_EN
  input  logic                  inj_sbe,
  input  logic                  inj_dbe,
`endif
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  wr_err,
  output logic                  rd_err,
  output logic                  sbe,
  output logic                  dbe,
  output logic [15:0]           sbe_cnt,
  output logic [15:0]           dbe_cnt,
  output logic                  mem_we,
  output logic [ADDR_WIDTH:0]   mem_wr_ptr,
  output logic [CW-1:0]         mem_din,
  output logic                  mem_re,
  output logic [ADDR_WIDTH:0]   mem_rd_ptr,
  input  logic [CW-1:0]         mem_dout,
  output logic                  mem_full,
  output logic                  mem_empty
);

  localparam int N = DATA_WIDTH + P;

  // Hamming positions are 1-based; codeword bit (pos-1) holds position pos.
  function automatic logic [CW-1:0] ecc_encode(input logic [DATA_WIDTH-1:0] d);
    logic [N-1:0] cw;
    logic         par;
    int           j;
    cw = '0;
    j  = 0;
    for (int pos = 1; pos <= N; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos-1] = d[j];
        j++;
      end
    end
    for (int k = 0; k < P; k++) begin
      par = 1'b0;
      for (int pos = 1; pos <= N; pos++)
        if (pos[k]) par ^= cw[pos-1];
      cw[(1 << k) - 1] = par;
    end
    return {^cw, cw};
  endfunction

  function automatic logic [P-1:0] ecc_syndrome(input logic [CW-1:0] c);
    logic [P-1:0] s;
    s = '0;
    for (int pos = 1; pos <= N; pos++)
      if (c[pos-1]) s ^= pos[P-1:0];
    return s;
  endfunction

  function automatic logic [CW-1:0] ecc_correct(input logic [CW-1:0] c, input logic [P-1:0] s);
    logic [CW-1:0] f;
    f = c;
    for (int pos = 1; pos <= N; pos++)
      if (s == pos[P-1:0]) f[pos-1] = ~f[pos-1];
    if (s == '0) f[CW-1] = ~f[CW-1];
    return f;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] ecc_extract(input logic [CW-1:0] c);
    logic [DATA_WIDTH-1:0] d;
    int                    j;
    d = '0;
    j = 0;
    for (int pos = 1; pos <= N; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[j] = c[pos-1];
        j++;
      end
    end
    return d;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                push, pop;

  assign full      = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {ADDR_WIDTH{1'b0}}};
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign count     = wr_ptr_q - rd_ptr_q;
  assign push      = wr_en & ~full;
  assign pop       = rd_en & ~empty;
  assign wr_ptr_d  = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, push};
  assign rd_ptr_d  = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, pop};

  assign mem_we     = push;
  assign mem_re     = pop;
  assign mem_wr_ptr = wr_ptr_q;
  assign mem_rd_ptr = rd_ptr_q;
  assign mem_full   = full;
  assign mem_empty  = empty;

`ifdef FIFO_ECC_INJECT_EN
  logic [CW-1:0] inj_mask;
  always_comb begin
    inj_mask = '0;
    if (inj_dbe)      inj_mask[1:0] = 2'b11;
    else if (inj_sbe) inj_mask[0]   = 1'b1;
  end
  assign mem_din = ecc_encode(wr_data) ^ inj_mask;
`else
  assign mem_din = ecc_encode(wr_data);
`endif

  logic wr_err_q, rd_err_q;

  always_ff @(posedge clk or posedge hw_rst) begin
    if (hw_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_err_q <= wr_en & full;
      rd_err_q <= rd_en & empty;
    end
  end

  assign wr_err = wr_err_q;
  assign rd_err = rd_err_q;

  // Stage 0: RAM read in flight; stage 1: RAM data captured; stage 2: decoded outputs.
  logic          vld_p0_q, vld_p1_q;
  logic [CW-1:0] dout_p1_q;

  always_ff @(posedge clk) begin
    if (vld_p0_q) dout_p1_q <= mem_dout;
  end

  logic [P-1:0]          syn_p1;
  logic                  par_p1, dec_sbe, dec_dbe;
  logic [DATA_WIDTH-1:0] dec_data;

  always_comb begin
    syn_p1   = ecc_syndrome(dout_p1_q);
    par_p1   = ^dout_p1_q;
    dec_sbe  = par_p1;
    dec_dbe  = ~par_p1 & (syn_p1 != '0);
    dec_data = par_p1 ? ecc_extract(ecc_correct(dout_p1_q, syn_p1)) : ecc_extract(dout_p1_q);
  end

  logic                  rd_valid_q, sbe_q, dbe_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [15:0]           sbe_cnt_q, dbe_cnt_q;

  always_ff @(posedge clk or posedge hw_rst) begin
    if (hw_rst) begin
      vld_p0_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      sbe_q      <= 1'b0;
      dbe_q      <= 1'b0;
      sbe_cnt_q  <= '0;
      dbe_cnt_q  <= '0;
    end else begin
      vld_p0_q   <= pop;
      vld_p1_q   <= vld_p0_q;
      rd_valid_q <= vld_p1_q;
      sbe_q      <= vld_p1_q & dec_sbe;
      dbe_q      <= vld_p1_q & dec_dbe;
      if (vld_p1_q) begin
        rd_data_q <= dec_data;
        if (dec_sbe) sbe_cnt_q <= sat_inc(sbe_cnt_q);
        if (dec_dbe) dbe_cnt_q <= sat_inc(dbe_cnt_q);
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign sbe      = sbe_q;
  assign dbe      = dbe_q;
  assign sbe_cnt  = sbe_cnt_q;
  assign dbe_cnt  = dbe_cnt_q;

endmodule

// File: tb/tb_sync_fifo_ecc_ctrl.sv
// Scoreboard bench for sync_fifo_ecc_ctrl: behavioural FIFO model, external RAM model with read-side bit flips.
module tb_sync_fifo_ecc_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int P     = 6;
  localparam int N     = DW + P;
  localparam int CW    = N + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          hw_rst = 1'b1;
  logic          wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, wr_err, rd_err, sbe, dbe;
  logic [AW:0]   count, mem_wr_ptr, mem_rd_ptr;
  logic [15:0]   sbe_cnt, dbe_cnt;
  logic          mem_we, mem_re, mem_full, mem_empty;
  logic [CW-1:0] mem_din, mem_dout;
`ifdef FIFO_ECC_INJECT_EN
  logic          inj_sbe = 1'b0, inj_dbe = 1'b0;
`endif

  sync_fifo_ecc_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .hw_rst(hw_rst),
`ifdef FIFO_ECC_INJECT_EN
    .inj_sbe(inj_sbe), .inj_dbe(inj_dbe),
`endif
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .full(full), .empty(empty), .count(count),
    .wr_err(wr_err), .rd_err(rd_err), .sbe(sbe), .dbe(dbe),
    .sbe_cnt(sbe_cnt), .dbe_cnt(dbe_cnt),
    .mem_we(mem_we), .mem_wr_ptr(mem_wr_ptr), .mem_din(mem_din),
    .mem_re(mem_re), .mem_rd_ptr(mem_rd_ptr), .mem_dout(mem_dout),
    .mem_full(mem_full), .mem_empty(mem_empty)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External RAM with registered read; rd_flip corrupts the word as it is read out.
  logic [CW-1:0] ram [DEPTH];
  logic [CW-1:0] rd_flip = '0;
  always @(posedge clk) begin
    if (mem_we) ram[mem_wr_ptr[AW-1:0]] <= mem_din;
    if (mem_re) mem_dout <= ram[mem_rd_ptr[AW-1:0]] ^ rd_flip;
  end

  typedef struct { logic [DW-1:0] data; logic [CW-1:0] cw; } ent_t;
  typedef struct { int due; logic [DW-1:0] data; logic sbe; logic dbe; } exp_t;
  ent_t fifo_q[$];
  exp_t exp_q[$];
  int   n_chk = 0, n_fail = 0;
  int   msbe = 0, mdbe = 0;
  int   wptr = 0, rptr = 0;
  logic exp_wr_err = 1'b0, exp_rd_err = 1'b0;
  int   dpos[DW];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Check bits equal the XOR of the positions of all set data bits, which zeroes the syndrome.
  function automatic logic [CW-1:0] ref_enc(input logic [DW-1:0] d);
    logic [N-1:0] cw;
    logic [P-1:0] x;
    cw = '0;
    x  = '0;
    for (int j = 0; j < DW; j++) begin
      cw[dpos[j]-1] = d[j];
      if (d[j]) x ^= P'(dpos[j]);
    end
    for (int k = 0; k < P; k++) cw[(1 << k) - 1] = x[k];
    return {^cw, cw};
  endfunction

  function automatic logic [DW-1:0] ref_raw(input logic [CW-1:0] c);
    logic [DW-1:0] d;
    for (int j = 0; j < DW; j++) d[j] = c[dpos[j]-1];
    return d;
  endfunction

  task automatic step(input logic we, input logic re, input logic [DW-1:0] d,
                      input logic [CW-1:0] flip, input logic isbe, input logic idbe);
    bit            push, pop;
    int            ne;
    logic [CW-1:0] imask, stored, rdw;
    ent_t          e;
    exp_t          x;
    chk("wr_err", wr_err, exp_wr_err);
    chk("rd_err", rd_err, exp_rd_err);
    wr_en = we; rd_en = re; wr_data = d; rd_flip = flip;
`ifdef FIFO_ECC_INJECT_EN
    inj_sbe = isbe; inj_dbe = idbe;
`endif
    #1;
    push = we && (fifo_q.size() < DEPTH);
    pop  = re && (fifo_q.size() > 0);
    chk("full", full, fifo_q.size() == DEPTH);
    chk("empty", empty, fifo_q.size() == 0);
    chk("count", count, fifo_q.size());
    chk("mem_full", mem_full, fifo_q.size() == DEPTH);
    chk("mem_empty", mem_empty, fifo_q.size() == 0);
    chk("mem_we", mem_we, push);
    chk("mem_re", mem_re, pop);
    chk("mem_wr_ptr", mem_wr_ptr, wptr);
    chk("mem_rd_ptr", mem_rd_ptr, rptr);
    imask = '0;
    if (idbe) imask[1:0] = 2'b11;
    else if (isbe) imask[0] = 1'b1;
    stored = ref_enc(d) ^ imask;
    if (push) chk("mem_din", mem_din, stored);
    if (pop) begin
      e      = fifo_q.pop_front();
      rdw    = e.cw ^ flip;
      ne     = $countones(rdw ^ ref_enc(e.data));
      x.due  = cyc + 3;
      x.sbe  = (ne == 1);
      x.dbe  = (ne == 2);
      x.data = (ne == 2) ? ref_raw(rdw) : e.data;
      exp_q.push_back(x);
      rptr = (rptr + 1) % (2 * DEPTH);
    end
    if (push) begin
      fifo_q.push_back('{d, stored});
      wptr = (wptr + 1) % (2 * DEPTH);
    end
    exp_wr_err = we && !push;
    exp_rd_err = re && !pop;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    hw_rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; rd_flip = '0;
    fifo_q.delete(); exp_q.delete();
    msbe = 0; mdbe = 0; wptr = 0; rptr = 0;
    exp_wr_err = 1'b0; exp_rd_err = 1'b0;
    #1;
    chk("rst count", count, 0);
    chk("rst empty", empty, 1);
    chk("rst full", full, 0);
    chk("rst rd_valid", rd_valid, 0);
    chk("rst rd_data", rd_data, 0);
    chk("rst sbe_cnt", sbe_cnt, 0);
    chk("rst dbe_cnt", dbe_cnt, 0);
    chk("rst flags", {wr_err, rd_err, sbe, dbe}, 0);
    @(negedge clk); @(negedge clk);
    hw_rst = 1'b0;
  endtask

  // Monitor: the DUT must present exactly the scheduled result at exactly its due cycle.
  initial begin : monitor
    exp_t x;
    logic exp_v;
    forever begin
      @(negedge clk);
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("rd_valid", rd_valid, exp_v);
      if (rd_valid && exp_v) begin
        x = exp_q.pop_front();
        if (x.sbe) msbe++;
        if (x.dbe) mdbe++;
        chk("rd_data", rd_data, x.data);
        chk("sbe", sbe, x.sbe);
        chk("dbe", dbe, x.dbe);
        chk("sbe_cnt", sbe_cnt, msbe);
        chk("dbe_cnt", dbe_cnt, mdbe);
      end
    end
  end

  initial begin : stim
    int            j;
    logic [CW-1:0] fl;
    int            r, b0, b1;
    j = 0;
    for (int i = 1; i <= N; i++)
      if ((i & (i - 1)) != 0) begin dpos[j] = i; j++; end
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    @(negedge clk);
    do_reset();

    // Single push then pop
    step(1'b1, 1'b0, 32'hDEADBEEF, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    idle(4);

    // Fill past full, then drain back to back
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 1'b0, $urandom, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h5555AAAA, '0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    idle(4);

    // Simultaneous push/pop on empty, then pop past empty
    step(1'b1, 1'b1, 32'hCAFEF00D, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    idle(4);

    // Interleaved incrementing data wrapping the pointers
    for (int i = 0; i < 40; i++) step(1'b1, i > 0, 32'h100 + i, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    idle(4);

`ifdef FIFO_ECC_INJECT_EN
    step(1'b1, 1'b0, 32'h12345678, '0, 1'b1, 1'b0);
    step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    idle(4);
    step(1'b1, 1'b0, 32'h0000FFFF, '0, 1'b0, 1'b1);
    step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    idle(4);
`endif

    // Reset between pop and rd_valid
    step(1'b1, 1'b0, 32'hA5A5A5A5, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h5A5A5A5A, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    do_reset();
    idle(4);

    // Random traffic with single and double bit read corruption
    for (int i = 0; i < 800; i++) begin
      fl = '0;
      r  = $urandom_range(0, 7);
      b0 = $urandom_range(0, CW - 1);
      b1 = (b0 + $urandom_range(1, CW - 1)) % CW;
      if (r == 0) fl[b0] = 1'b1;
      else if (r == 1) begin fl[b0] = 1'b1; fl[b1] = 1'b1; end
      step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, $urandom, fl, 1'b0, 1'b0);
    end
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, '0, '0, 1'b0, 1'b0);
    idle(5);
    chk("pending reads", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
